axis_mash11_dsm_dac: RTL
========================

# axis_mash11_dsm_dac

Parametrised delta-sigma DAC modulator with an AXI-Stream input. Selectable first-order or MASH 1-1 (second-order) noise shaping, and a built-in zero-order-hold oversampler. It accepts one signed PCM sample every OSR clocks and produces one modulator output word per clock. The block sits between the sample source / interpolation chain and the DAC output stage: a 1-bit pin driver in MODE 0, or a 4-level driver / resistor network in MODE 1.

## Interface
- WIDTH, 16: input sample width, signed two's complement; also the accumulator width (≥4).
- OSR, 64: oversampling ratio, i.e. clocks per accepted input sample (≥1).
- MODE, 1: 0 = first-order (single accumulator); 1 = MASH 1-1.

- aclk  in  1  clock.
- arst  in  1  reset, asynchronous, active-high. One clock domain; reset polarity and synchronicity are fixed as stated here.
- s_axis_data_tdata  in  WIDTH  signed input sample.
- s_axis_data_tvalid  in  1  input sample valid.
- s_axis_data_tready  out  1  block can accept a sample this cycle.
- m_axis_data_tdata  out  3  signed modulator output, range −1..+2.
- m_axis_data_tvalid  out  1  output valid (no backpressure).
- underrun  out  1  one-cycle pulse when a sample slot passed with no input available.

## Operation
- Offset conversion: u = s_axis_data_tdata with its MSB inverted, giving an unsigned value 0..2^WIDTH−1. 0x8000 maps to 0 and 0x7FFF maps to 65535 (for WIDTH=16).
- Holding register din (WIDTH bits) stores u on every input handshake (tvalid & tready).
- primed flag: cleared by reset, set on the first handshake, and stays set afterwards.
- Slot counter osr_cnt, range 0..OSR−1:
  - holds at 0 while not primed;
  - increments every clock while primed, wrapping from OSR−1 to 0.
- s_axis_data_tready = ~primed | (osr_cnt == OSR−1), driven combinationally from registers. For OSR=1 it is constant 1 once primed.
- Underrun: on a clock where primed & osr_cnt==OSR−1 & ~tvalid:
  - din holds its old value (zero-order hold continues);
  - underrun is registered high for exactly the next cycle.
- Modulator step, on every clock where primed was 1 before the edge:
  - sum1 = acc1 + din, WIDTH+1 bits; c1 = sum1[WIDTH]; acc1 ← sum1[WIDTH−1:0].
  - sum2 = acc2 + sum1[WIDTH−1:0], WIDTH+1 bits; c2 = sum2[WIDTH]; acc2 ← sum2[WIDTH−1:0]; c2_d ← c2.
  - MODE 1: y = c1 + c2 − c2_d, computed in 3-bit signed (values −1, 0, 1, 2).
  - MODE 0: y = c1, zero-extended. The stage-2 logic must not be instantiated.
  - m_axis_data_tdata ← y; m_axis_data_tvalid ← 1.
- Mean output equals din / 2^WIDTH. The modulator never stops once primed; there is no output backpressure.
- Arithmetic is modular within WIDTH bits. Only the carries leave the accumulators, so no saturation logic is needed.

## Timing
- Reset values: acc1, acc2, c2_d, din, osr_cnt = 0; primed = 0; m_axis_data_tdata = 0; m_axis_data_tvalid = 0; underrun = 0. s_axis_data_tready = 1 immediately on reset.
- First handshake at edge t0:
  - the first modulator output is registered at edge t0+1, and m_axis_data_tvalid rises with it;
  - tvalid stays high until reset.
- Subsequent handshakes occur only at edges t0 + k·OSR. A new din first affects the step at the following edge (latency 1).
- Input tdata is ignored whenever tready=0; no handshake occurs.
- Simultaneous handshake and slot boundary: the new sample wins and underrun stays 0.
- If arst is asserted mid-stream, all state clears asynchronously. After release the block waits for a new first sample, with tready=1 and tvalid out = 0.

## Test plan
- Reset/idle (WIDTH=16, OSR=4, MODE=1): no input → tready=1, m_tvalid=0, m_tdata=0, underrun=0 indefinitely.
- Midscale (input 0x0000 held valid, OSR=4): m_tdata sequence from first valid is 0,1,1,0 repeating. Handshakes occur exactly every 4 clocks, tready is high 1 clock in 4, and underrun never fires.
- Extremes: input 0x8000 → m_tdata always 0. Input 0x7FFF with MODE=0 → exactly one 0 in every 65536 outputs.
- DC accuracy: constant input 0x1234 (u=0x9234), MODE 1 → the sum of 65536 consecutive outputs from the first valid lies in 0x9234..0x9235, and every output is in −1..2.
- Underrun (OSR=8): drop tvalid for one slot → underrun high for exactly 1 cycle, din unchanged, output pattern continues, next handshake 8 clocks later.
- Reset mid-stream: assert arst asynchronously between edges during a midscale run → all outputs 0 at once. After release and a re-sent first sample, the sequence restarts at 0,1,1,0.

Source files
------------

// File: rtl/axis_mash11_dsm_dac.sv
// axis_mash11_dsm_dac: AXI-Stream fed delta-sigma DAC modulator.
// Holds each accepted PCM sample for OSR clocks (zero-order hold) and runs
// either a first-order accumulator or a MASH 1-1 cascade on it every clock.
module axis_mash11_dsm_dac #(
  parameter int WIDTH = 16,
  parameter int OSR   = 64,
  parameter int MODE  = 1
) (
  input  logic             aclk,
  input  logic             arst,
  input  logic [WIDTH-1:0] s_axis_data_tdata,
  input  logic             s_axis_data_tvalid,
  output logic             s_axis_data_tready,
  output logic [2:0]       m_axis_data_tdata,
  output logic             m_axis_data_tvalid,
  output logic             underrun
);

  localparam int            CW       = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(OSR - 1);

  logic             r_primed;
  logic [CW-1:0]    r_osr_cnt;
  logic [WIDTH-1:0] r_din;
  logic [WIDTH-1:0] r_acc1;
  logic [2:0]       r_y;
  logic             r_tvalid;
  logic             r_underrun;

  logic             w_last;
  logic             w_hs;
  logic [WIDTH:0]   w_sum1;
  logic             w_c1;
  logic [2:0]       w_y;

  // The last count of a slot is the only time a new sample may enter.
  assign w_last             = (r_osr_cnt == CNT_LAST);
  assign s_axis_data_tready = ~r_primed | w_last;
  assign w_hs               = s_axis_data_tvalid & s_axis_data_tready;

  // Stage 1: only the carry out of the accumulator leaves it.
  assign w_sum1 = {1'b0, r_acc1} + {1'b0, r_din};
  assign w_c1   = w_sum1[WIDTH];

  generate
    if (MODE == 1) begin : g_mash
      logic [WIDTH-1:0] r_acc2;
      logic             r_c2_d;
      logic [WIDTH:0]   w_sum2;

      // Stage 2 integrates the stage-1 residue; its carry is differentiated.
      assign w_sum2 = {1'b0, r_acc2} + {1'b0, w_sum1[WIDTH-1:0]};
      assign w_y    = {2'b00, w_c1} + {2'b00, w_sum2[WIDTH]} - {2'b00, r_c2_d};

      // Second accumulator and delayed carry advance with every modulator step.
      always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
          r_acc2 <= {WIDTH{1'b0}};
          r_c2_d <= 1'b0;
        end else if (r_primed) begin
          r_acc2 <= w_sum2[WIDTH-1:0];
          r_c2_d <= w_sum2[WIDTH];
        end
      end
    end else begin : g_first
      assign w_y = {2'b00, w_c1};
    end
  endgenerate

  // Priming flag and slot counter that paces input acceptance.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_primed  <= 1'b0;
      r_osr_cnt <= {CW{1'b0}};
    end else begin
      if (w_hs) begin
        r_primed <= 1'b1;
      end
      if (r_primed) begin
        if (w_last) begin
          r_osr_cnt <= {CW{1'b0}};
        end else begin
          r_osr_cnt <= r_osr_cnt + CW'(1);
        end
      end
    end
  end

  // Capture offset-binary sample on handshake; flag a slot that went unfilled.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_din      <= {WIDTH{1'b0}};
      r_underrun <= 1'b0;
    end else begin
      if (w_hs) begin
        r_din <= {~s_axis_data_tdata[WIDTH-1], s_axis_data_tdata[WIDTH-2:0]};
      end
      r_underrun <= r_primed & w_last & ~s_axis_data_tvalid;
    end
  end

  // Stage-1 accumulator and registered modulator output.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_acc1   <= {WIDTH{1'b0}};
      r_y      <= 3'b000;
      r_tvalid <= 1'b0;
    end else if (r_primed) begin
      r_acc1   <= w_sum1[WIDTH-1:0];
      r_y      <= w_y;
      r_tvalid <= 1'b1;
    end
  end

  assign m_axis_data_tdata  = r_y;
  assign m_axis_data_tvalid = r_tvalid;
  assign underrun           = r_underrun;

endmodule
